// File: rtl/sr_cmd_pkg.sv
// Shared types and default parameters for the SR latch command stage.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SET_P = 2'd2,
        ST_RST_P = 2'd3
    } state_e;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE    = 16;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_PULSE_LEN   = 2;

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer, debounce counter and rising-edge request pulse.
module btn_debounce
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic req
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_v;
    logic                   stable;
    logic [CNT_W-1:0]       cnt;
    logic                   hit;

    assign sync_v = sync[SYNC_STAGES-1];
    assign hit    = (cnt == CNT_W'(DEBOUNCE - 1));

    // A new level is accepted only after DEBOUNCE consecutive differing samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync   <= '0;
            stable <= 1'b0;
            cnt    <= '0;
            req    <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn};
            req  <= 1'b0;
            if (sync_v == stable) begin
                cnt <= '0;
            end else if (hit) begin
                stable <= sync_v;
                cnt    <= '0;
                req    <= sync_v;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sr_cmd_debounce.sv
// Command stage for the NOR SR latch: debounced buttons to clean s/r pulses.
module sr_cmd_debounce
    import sr_cmd_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE    = DEF_DEBOUNCE,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int PULSE_LEN   = DEF_PULSE_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic set_btn,
    input  logic rst_btn,
    output logic s,
    output logic r,
    output logic q_mirror,
    output logic busy,
    output logic conflict
);

    localparam int PW = $clog2(PULSE_LEN + 1);

    state_e        state;
    logic [PW-1:0] pcnt;
    logic          req_s;
    logic          req_r;
    logic          pend_s;
    logic          pend_r;
    logic          want_s;
    logic          want_r;
    logic          done;

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE),
        .CNT_W      (CNT_W)
    ) u_set (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (set_btn),
        .req  (req_s)
    );

    btn_debounce #(
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE),
        .CNT_W      (CNT_W)
    ) u_rst (
        .clk  (clk),
        .rst_n(rst_n),
        .btn  (rst_btn),
        .req  (req_r)
    );

    assign want_s = req_s | pend_s;
    assign want_r = req_r | pend_r;
    assign done   = (pcnt == PW'(PULSE_LEN));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_INIT;
            pcnt     <= '0;
            s        <= 1'b0;
            r        <= 1'b0;
            q_mirror <= 1'b0;
            busy     <= 1'b0;
            conflict <= 1'b0;
            pend_s   <= 1'b0;
            pend_r   <= 1'b0;
        end else begin
            conflict <= 1'b0;
            // Requests seen outside IDLE are held one-deep until IDLE
            if (state == ST_IDLE) begin
                pend_s <= 1'b0;
                pend_r <= 1'b0;
            end else begin
                pend_s <= pend_s | req_s;
                pend_r <= pend_r | req_r;
            end
            unique case (state)
                ST_INIT: begin
                    if (done) begin
                        r     <= 1'b0;
                        busy  <= 1'b0;
                        pcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        r    <= 1'b1;
                        busy <= 1'b1;
                        pcnt <= pcnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (want_s && want_r) begin
                        conflict <= 1'b1;
                    end else if (want_s && !q_mirror) begin
                        s        <= 1'b1;
                        q_mirror <= 1'b1;
                        busy     <= 1'b1;
                        pcnt     <= PW'(1);
                        state    <= ST_SET_P;
                    end else if (want_r && q_mirror) begin
                        r        <= 1'b1;
                        q_mirror <= 1'b0;
                        busy     <= 1'b1;
                        pcnt     <= PW'(1);
                        state    <= ST_RST_P;
                    end
                end
                ST_SET_P: begin
                    if (done) begin
                        s     <= 1'b0;
                        busy  <= 1'b0;
                        pcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                ST_RST_P: begin
                    if (done) begin
                        r     <= 1'b0;
                        busy  <= 1'b0;
                        pcnt  <= '0;
                        state <= ST_IDLE;
                    end else begin
                        pcnt <= pcnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    a_no_sr: assert property (@(posedge clk) disable iff (!rst_n) !(s && r));

endmodule

// File: tb/tb_sr_cmd_debounce.sv
// Directed bench for sr_cmd_debounce with DEBOUNCE=4, SYNC_STAGES=2, PULSE_LEN=2.
module tb_sr_cmd_debounce;

    logic clk = 1'b0;
    logic rst_n;
    logic set_btn;
    logic rst_btn;
    logic s;
    logic r;
    logic q_mirror;
    logic busy;
    logic conflict;

    int n_vec = 0;
    int n_bad = 0;

    int cyc;
    int s_hi, r_hi, c_hi;
    int s_rise, r_rise;
    int s_first, r_first;
    logic s_prev, r_prev;

    sr_cmd_debounce #(
        .SYNC_STAGES(2),
        .DEBOUNCE   (4),
        .CNT_W      (16),
        .PULSE_LEN  (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_btn (set_btn),
        .rst_btn (rst_btn),
        .s       (s),
        .r       (r),
        .q_mirror(q_mirror),
        .busy    (busy),
        .conflict(conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc     = 0;
        s_hi    = 0;
        r_hi    = 0;
        c_hi    = 0;
        s_rise  = 0;
        r_rise  = 0;
        s_first = -1;
        r_first = -1;
        s_prev  = s;
        r_prev  = r;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
            if (s) s_hi++;
            if (r) r_hi++;
            if (conflict) c_hi++;
            if (s && !s_prev) begin
                if (s_rise == 0) s_first = cyc;
                s_rise++;
            end
            if (r && !r_prev) begin
                if (r_rise == 0) r_first = cyc;
                r_rise++;
            end
            s_prev = s;
            r_prev = r;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        set_btn = 1'b0;
        rst_btn = 1'b0;
        clr();

        // reset state
        run(3);
        check("rst_s", s, 0);
        check("rst_r", r, 0);
        check("rst_q", q_mirror, 0);
        check("rst_busy", busy, 0);
        check("rst_conf", conflict, 0);

        // INIT pulse after release
        rst_n = 1'b1;
        run(1);
        check("init_r1", r, 1);
        check("init_busy", busy, 1);
        run(1);
        check("init_r2", r, 1);
        run(1);
        check("init_r_end", r, 0);
        check("init_busy_end", busy, 0);
        check("init_q", q_mirror, 0);
        run(4);

        // clean set step: s rises on the 7th sample
        set_btn = 1'b1;
        run(6);
        check("set_lat_s0", s, 0);
        run(1);
        check("set_s1", s, 1);
        check("set_q", q_mirror, 1);
        check("set_busy", busy, 1);
        run(1);
        check("set_s2", s, 1);
        run(1);
        check("set_s_end", s, 0);
        check("set_busy_end", busy, 0);

        // redundant second set press
        set_btn = 1'b0;
        run(10);
        set_btn = 1'b1;
        clr();
        run(15);
        check("redund_s", s_rise, 0);
        check("redund_q", q_mirror, 1);
        set_btn = 1'b0;
        run(10);

        // bouncy reset button then stable high
        clr();
        for (int i = 0; i < 5; i++) begin
            rst_btn = 1'b1;
            run(2);
            rst_btn = 1'b0;
            run(2);
        end
        check("bounce_none", r_rise, 0);
        rst_btn = 1'b1;
        run(20);
        check("bounce_rpulse", r_rise, 1);
        check("bounce_rlen", r_hi, 2);
        check("bounce_spulse", s_rise, 0);
        check("bounce_q", q_mirror, 0);
        rst_btn = 1'b0;
        run(10);

        // simultaneous set and reset
        clr();
        set_btn = 1'b1;
        rst_btn = 1'b1;
        run(20);
        check("both_s", s_rise, 0);
        check("both_r", r_rise, 0);
        check("both_conf", c_hi, 1);
        check("both_q", q_mirror, 0);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        run(10);

        // reset request lands while s is high
        clr();
        set_btn = 1'b1;
        run(1);
        rst_btn = 1'b1;
        run(20);
        check("pend_spulse", s_rise, 1);
        check("pend_slen", s_hi, 2);
        check("pend_rpulse", r_rise, 1);
        check("pend_rlen", r_hi, 2);
        check("pend_gap", r_first - s_first, 3);
        check("pend_q", q_mirror, 0);
        check("pend_conf", c_hi, 0);
        set_btn = 1'b0;
        rst_btn = 1'b0;
        run(10);

        // asynchronous reset mid pulse
        set_btn = 1'b1;
        run(7);
        check("mid_s_hi", s, 1);
        rst_n = 1'b0;
        #1;
        check("mid_s_async", s, 0);
        check("mid_q_async", q_mirror, 0);
        check("mid_busy_async", busy, 0);
        set_btn = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(1);
        check("reinit_r1", r, 1);
        run(1);
        check("reinit_r2", r, 1);
        run(1);
        check("reinit_r_end", r, 0);
        check("reinit_s", s, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sr_cmd_debounce.md
Name: sr_cmd_debounce

Overview:
- Upstream command stage for the NOR SR latch. Converts two raw, bouncy push-button inputs (set, reset) into clean, registered s/r pulses for the latch.
- Guarantees the forbidden combination s=r=1 is never driven.
- Drives the latch into a known state after reset.
- Tracks the expected latch output in q_mirror so downstream logic can check the latch.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of each input synchronizer (minimum 2).
- DEBOUNCE, 16, consecutive stable synchronized cycles required to accept a level change (minimum 2).
- CNT_W, 16, width of the debounce counters. Must satisfy 2^CNT_W > DEBOUNCE.
- PULSE_LEN, 2, number of cycles s or r is held high per command (minimum 1).

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- set_btn  input  1  raw asynchronous set request, active-high.
- rst_btn  input  1  raw asynchronous reset request, active-high.
- s  output  1  registered set drive to the latch.
- r  output  1  registered reset drive to the latch.
- q_mirror  output  1  expected latch q after the last issued command.
- busy  output  1  high while a pulse is being driven (INIT, SET_P, RST_P).
- conflict  output  1  one-cycle flag: simultaneous set and reset requests were dropped.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n). While rst_n=0, all flops clear: synchronizers, stable levels, counters, pending flags. Outputs: s=0, r=0, q_mirror=0, busy=0, conflict=0, FSM=INIT.
- Synchronizer: each button passes through SYNC_STAGES flops.
- Debounce, per input:
  - If the synchronized value equals the stable level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE-1, the stable level takes the new value and the counter clears.
  - Any bounce back to the stable level before then clears the counter.
- Request: a one-cycle req_s / req_r is generated on each 0->1 edge of the stable level. Falling edges generate nothing.
- Latency: a clean step on a button produces s or r at SYNC_STAGES + DEBOUNCE + 1 cycles (±1) after the edge.
- FSM states:
  - INIT: after rst_n rises, drives r=1 for PULSE_LEN cycles, then goes to IDLE. q_mirror stays 0.
  - IDLE: s=r=0, busy=0. Request handling:
    - req_s and req_r in the same cycle: both dropped, conflict=1 for one cycle, stay in IDLE.
    - req_s with q_mirror=0: go to SET_P.
    - req_r with q_mirror=1: go to RST_P.
    - A request matching the current q_mirror is redundant: suppressed, no pulse.
  - SET_P: s=1 for PULSE_LEN cycles. q_mirror becomes 1 on the cycle s first asserts. Then return to IDLE.
  - RST_P: r=1 for PULSE_LEN cycles. q_mirror becomes 0 on the cycle r first asserts. Then return to IDLE.
- Pending requests:
  - A request arriving during INIT, SET_P or RST_P sets a one-deep pending flag (pend_s or pend_r).
  - On return to IDLE, pending flags are evaluated exactly like fresh requests, including redundancy suppression and conflict.
  - Pending flags clear once evaluated. Repeated same-type requests during one pulse collapse into one.
  - If pend_s and pend_r are both set, both are dropped and conflict=1.
- s and r are driven directly from flops, never from combinational logic. An assertion must check that s and r are never both 1.
- If rst_n is asserted mid-pulse, s and r fall immediately (asynchronous) and the INIT sequence reruns after release.
- Buttons held high produce no further requests.

Decomposition:
- Package sr_cmd_pkg:
  - FSM state enum: INIT, IDLE, SET_P, RST_P.
  - Default parameter constants.
- Sub-module btn_debounce (synchronizer + debounce counter + rising-edge pulse). Instantiated twice, once per button, with the same parameters.
- The top level contains the FSM, the pending flags and the pulse counter (width $clog2(PULSE_LEN+1)).

Test Plan (DEBOUNCE=4, SYNC_STAGES=2, PULSE_LEN=2):
- Reset release: r=1 for 2 cycles, then s=r=0, busy=0, q_mirror=0.
- Clean set_btn step: s=1 for exactly 2 cycles about 7 cycles after the step, q_mirror=1. A second set press produces no pulse.
- Bouncy rst_btn (toggling every 2 cycles for 10 cycles, then stable high, with q_mirror=1): exactly one r pulse of 2 cycles, q_mirror=0.
- set_btn and rst_btn rise in the same cycle: no s/r pulse, conflict=1 for one cycle, q_mirror unchanged.
- set press, then rst press debounced while s is high: s pulse, then an r pulse immediately after returning to IDLE; final q_mirror=0.
- rst_n dropped during an s pulse: s=0 within the same time step, and INIT's r pulse is seen after release.
